// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA controller and CPU memory-port owner
module oam_dma #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004,
  parameter int          DMA_LEN  = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  output logic        dma_busy,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_page;
  logic [7:0]  r_idx;
  logic        r_parity;
  logic        w_trigger;

  // A trigger is only recognised while idle; during DMA the CPU inputs are ignored.
  assign w_trigger = cpu_we && (cpu_addr == DMA_REG);

  // Read data always goes straight back to the CPU, so CPU read latency equals mem latency.
  assign cpu_dout = mem_dout;
  assign dma_busy = ~cpu_rdy;

  // State, page/index bookkeeping and the free-running parity toggle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_page   <= 8'h00;
      r_idx    <= 8'h00;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_parity <= ~r_parity;
      if (r_state == S_IDLE && w_trigger) begin
        r_page <= cpu_din;
        r_idx  <= 8'h00;
      end else if (r_state == S_WRITE && r_idx != LAST_IDX) begin
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  // Next-state decode and memory-port mux: pass-through when idle, DMA-driven otherwise.
  always_comb begin
    w_next_state = r_state;
    cpu_rdy      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {r_page, 8'h00};
    mem_din      = 8'h00;
    case (r_state)
      S_IDLE: begin
        cpu_rdy  = 1'b1;
        mem_we   = cpu_we & ~w_trigger;
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        if (w_trigger) begin
          w_next_state = S_HALT;
        end
      end
      S_HALT: begin
        // An odd parity cycle costs one extra dead cycle before the first read.
        w_next_state = r_parity ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        w_next_state = S_READ;
      end
      S_READ: begin
        mem_addr     = {r_page, r_idx};
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        mem_we       = 1'b1;
        mem_addr     = OAM_DATA;
        mem_din      = mem_dout;
        w_next_state = (r_idx == LAST_IDX) ? S_IDLE : S_READ;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard testbench for oam_dma
module tb_oam_dma;

  logic        clk;
  logic        reset_n;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_rdy;
  logic        dma_busy;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  int checks;
  int failures;
  int oam_cnt;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] prev_addr;
  logic [7:0]  tb_mem [0:65535];
  logic        tb_par;

  oam_dma dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_rdy  (cpu_rdy),
    .dma_busy (dma_busy),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared memory: synchronous write, registered read (old data on collision).
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_din;
    mem_dout <= tb_mem[mem_addr];
  end

  // Expected parity: cleared by reset, toggles on every other edge.
  always @(posedge clk) begin
    tb_par <= reset_n ? ~tb_par : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every OAM write pops the scoreboard; its source address is the previous cycle's address.
  initial begin
    oam_cnt   = 0;
    prev_addr = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && mem_we === 1'b1 && mem_addr == 16'h2004) begin
        oam_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_oam_write", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("oam_data", {24'd0, mem_din}, {24'd0, mon_e.data});
          chk("oam_src_addr", {16'd0, prev_addr}, {16'd0, mon_e.addr});
        end
      end
      if (mem_we === 1'b1 && mem_addr == 16'h4014) chk("trigger_forwarded", 32'd1, 32'd0);
      if (dma_busy === 1'b1 && mem_addr == 16'h0000) chk("addr_wrap_0000", 32'd1, 32'd0);
      prev_addr = mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_we   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    tick();
    cpu_we   = 1'b0;
  endtask

  task automatic cpu_rd_chk(input string name, input logic [15:0] a, input logic [7:0] req);
    cpu_we   = 1'b0;
    cpu_addr = a;
    tick();
    chk(name, {24'd0, cpu_dout}, {24'd0, req});
    chk("passthru_rdy", {31'd0, cpu_rdy}, 32'd1);
  endtask

  task automatic preload(input logic [7:0] page, input logic [7:0] key);
    for (int i = 0; i < 256; i++) begin
      cpu_wr({page, 8'(i)}, 8'(i) ^ key);
    end
  endtask

  // Launch one DMA; 'align' selects parity in the HALT cycle, rst_after>0 resets after that many writes.
  task automatic run_dma(input logic [7:0] page, input logic align, input logic noise,
                         input int n_exp, input logic [7:0] key, input int rst_after,
                         output int low);
    int base;
    int guard;
    guard = 0;
    while (tb_par !== ~align && guard < 4) begin
      tick();
      guard++;
    end
    for (int i = 0; i < n_exp; i++) begin
      exp_q.push_back({page, 8'(i), 8'(i) ^ key});
    end
    base     = oam_cnt;
    cpu_we   = 1'b1;
    cpu_addr = 16'h4014;
    cpu_din  = page;
    #1;
    chk("trigger_not_forwarded", {31'd0, mem_we}, 32'd0);
    tick();
    cpu_we = 1'b0;
    low    = 0;
    while (cpu_rdy === 1'b0 && low < 700) begin
      low++;
      if (noise) begin
        cpu_we   = 1'($urandom_range(0, 1));
        cpu_addr = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
        cpu_din  = 8'($urandom);
      end
      if (rst_after > 0 && (oam_cnt - base) >= rst_after) begin
        reset_n = 1'b0;
        tick();
        chk("rst_mid_rdy", {31'd0, cpu_rdy}, 32'd1);
        chk("rst_mid_busy", {31'd0, dma_busy}, 32'd0);
        reset_n = 1'b1;
        break;
      end
      tick();
    end
    cpu_we = 1'b0;
  endtask

  int low;

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    cpu_we   = 1'b1;
    cpu_addr = 16'h4014;
    cpu_din  = 8'h02;
    tick();
    tick();
    chk("reset_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("reset_busy", {31'd0, dma_busy}, 32'd0);
    chk("reset_passthru_addr", {16'd0, mem_addr}, 32'h4014);
    chk("reset_trigger_we", {31'd0, mem_we}, 32'd0);
    cpu_we  = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("trigger_in_reset_ignored", {31'd0, dma_busy}, 32'd0);

    // Pass-through write then read.
    cpu_wr(16'h0123, 8'hA5);
    cpu_rd_chk("passthru_read", 16'h0123, 8'hA5);

    preload(8'h02, 8'h3C);
    preload(8'hFF, 8'hC3);

    // Even start: 513 halted cycles.
    run_dma(8'h02, 1'b0, 1'b0, 256, 8'h3C, 0, low);
    chk("even_low_cycles", 32'(low), 32'd513);
    chk("even_queue_drained", 32'(exp_q.size()), 32'd0);

    // Odd start: ALIGN inserted, 514 halted cycles.
    run_dma(8'h02, 1'b1, 1'b0, 256, 8'h3C, 0, low);
    chk("odd_low_cycles", 32'(low), 32'd514);
    chk("odd_queue_drained", 32'(exp_q.size()), 32'd0);

    // Page FF: reads FF00..FFFF, no wrap into 0000.
    run_dma(8'hFF, 1'b0, 1'b0, 256, 8'hC3, 0, low);
    chk("pageff_low_cycles", 32'(low), 32'd513);
    chk("pageff_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("pageff_idle_rdy", {31'd0, cpu_rdy}, 32'd1);

    // Reset after the 100th OAM write.
    run_dma(8'h02, 1'b0, 1'b0, 100, 8'h3C, 100, low);
    repeat (20) tick();
    chk("rst_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rst_oam_writes_stopped", {31'd0, dma_busy}, 32'd0);
    cpu_wr(16'h0456, 8'h5A);
    cpu_rd_chk("rst_passthru_read", 16'h0456, 8'h5A);

    // CPU noise during DMA, including re-trigger attempts.
    void'($urandom(32'd1234));
    run_dma(8'h02, 1'b0, 1'b1, 256, 8'h3C, 0, low);
    chk("noise_low_cycles", 32'(low), 32'd513);
    repeat (10) tick();
    chk("noise_single_dma", {31'd0, dma_busy}, 32'd0);
    chk("noise_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
